// File: rtl/nios2_gen2_cpu_ocimem_arbiter.sv
// OCI RAM arbiter for the Nios II gen2 debug module: latches JTAG ocimem commands,
// round-robins them against the CPU debug slave and sequences fixed-latency RAM accesses.
module nios2_gen2_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a_i,
    input  logic              take_action_ocimem_b_i,
    input  logic [37:0]       jdo_i,
    output logic [31:0]       MonDReg_o,
    output logic              monitor_ready_o,
    output logic              monitor_error_o,
    output logic              jtag_busy_o,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [31:0]       avs_writedata_i,
    input  logic              avs_debugaccess_i,
    output logic [31:0]       avs_readdata_o,
    output logic              avs_waitrequest_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_ADDR, S_RD_DATA} state_t;

    state_t            state_q, state_d;
    logic              owner_jtag_q, owner_jtag_d;
    logic              last_jtag_q, last_jtag_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
    logic [31:0]       jtag_wdata_q, jtag_wdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;

    logic active, op_done, jtag_done, cpu_done, jtag_inflight, cpu_req, grant_jtag;
    logic jdo_unused;

    assign jdo_unused    = ^{jdo_i[37:36], jdo_i[1:0]};
    assign active        = (state_q != S_IDLE);
    assign op_done       = (state_q == S_WR) || (state_q == S_RD_DATA);
    assign jtag_done     = op_done & owner_jtag_q;
    assign cpu_done      = op_done & ~owner_jtag_q;
    // The completion cycle no longer blocks a new command.
    assign jtag_inflight = pend_q | (active & owner_jtag_q & ~jtag_done);
    assign cpu_req       = avs_read_i | avs_write_i;
    assign grant_jtag    = pend_q & (~cpu_req | ~last_jtag_q);

    always_comb begin
        state_d      = state_q;
        owner_jtag_d = owner_jtag_q;
        last_jtag_d  = last_jtag_q;
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        jtag_addr_d  = jtag_addr_q;
        jtag_wdata_d = jtag_wdata_q;
        mon_d        = mon_q;
        ready_d      = ready_q;
        error_d      = error_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_jtag) begin
                    owner_jtag_d = 1'b1;
                    last_jtag_d  = 1'b1;
                    pend_d       = 1'b0;
                    ram_addr_d   = jtag_addr_q;
                    ram_wdata_d  = jtag_wdata_q;
                    ram_we_d     = pend_wr_q;
                    state_d      = pend_wr_q ? S_WR : S_RD_ADDR;
                end else if (cpu_req) begin
                    owner_jtag_d = 1'b0;
                    last_jtag_d  = 1'b0;
                    ram_addr_d   = avs_address_i;
                    ram_wdata_d  = avs_writedata_i;
                    ram_we_d     = avs_write_i & avs_debugaccess_i;
                    state_d      = avs_write_i ? S_WR : S_RD_ADDR;
                end
            end
            S_WR:      state_d = S_IDLE;
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (jtag_done) begin
            ready_d     = 1'b1;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
            if (state_q == S_RD_DATA) mon_d = ram_rdata_i;
        end

        // A newly accepted command overrides the completion updates above.
        if (take_action_ocimem_a_i || take_action_ocimem_b_i) begin
            if (jtag_inflight) begin
                error_d = 1'b1;
            end else if (take_action_ocimem_a_i) begin
                jtag_addr_d = jdo_i[ADDR_W+1:2];
                ready_d     = 1'b0;
                error_d     = take_action_ocimem_b_i;
                if (jdo_i[35]) begin
                    pend_d    = 1'b1;
                    pend_wr_d = 1'b0;
                end
            end else begin
                jtag_wdata_d = jdo_i[34:3];
                ready_d      = 1'b0;
                pend_d       = 1'b1;
                pend_wr_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_jtag_q <= 1'b0;
            last_jtag_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            jtag_addr_q  <= '0;
            jtag_wdata_q <= '0;
            mon_q        <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_jtag_q <= owner_jtag_d;
            last_jtag_q  <= last_jtag_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            jtag_addr_q  <= jtag_addr_d;
            jtag_wdata_q <= jtag_wdata_d;
            mon_q        <= mon_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign MonDReg_o         = mon_q;
    assign monitor_ready_o   = ready_q;
    assign monitor_error_o   = error_q;
    assign jtag_busy_o       = pend_q | (active & owner_jtag_q);
    assign avs_waitrequest_o = reset | (cpu_req & ~cpu_done);
    assign avs_readdata_o    = (state_q == S_RD_DATA) ? ram_rdata_i : 32'h0;
    assign ram_addr_o        = ram_addr_q;
    // Gated so a write already queued cannot land once reset is asserted.
    assign ram_we_o          = ram_we_q & ~reset;
    assign ram_wdata_o       = ram_wdata_q;

endmodule

// File: tb/tb_nios2_gen2_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed vector table, randomized ops against a
// memory-level reference model, and hand sequences for contention/error/reset cases.
module tb_nios2_gen2_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ta_a = 1'b0, ta_b = 1'b0;
    logic [37:0] jdo = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, jtag_busy;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0, avs_debugaccess = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0, failures = 0;
    int we_viol = 0;
    bit no_we_window = 1'b0;

    nios2_gen2_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a_i(ta_a), .take_action_ocimem_b_i(ta_b), .jdo_i(jdo),
        .MonDReg_o(MonDReg), .monitor_ready_o(monitor_ready), .monitor_error_o(monitor_error),
        .jtag_busy_o(jtag_busy),
        .avs_address_i(avs_address), .avs_read_i(avs_read), .avs_write_i(avs_write),
        .avs_writedata_i(avs_writedata), .avs_debugaccess_i(avs_debugaccess),
        .avs_readdata_o(avs_readdata), .avs_waitrequest_o(avs_waitrequest),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (no_we_window && ram_we) we_viol <= we_viol + 1;
    end

    typedef struct {
        int          kind;   // 0 CPU wr, 1 CPU rd, 2 JTAG a+b wr, 3 JTAG b-only wr, 4 JTAG rd
        logic [7:0]  addr;
        logic [31:0] data;
        bit          da;
        logic [31:0] exp;
        int          lat;    // CPU wait cycles or JTAG strobe-to-ready cycles
    } vec_t;

    logic [31:0] ref_mem [256];
    bit          ref_valid [256];
    logic [7:0]  ref_jaddr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cpu_op(input bit wr, input bit both, input logic [7:0] a, input logic [31:0] d,
                          input bit da, output logic [31:0] rd, output int waits);
        avs_address = a; avs_writedata = d; avs_debugaccess = da;
        avs_write = wr; avs_read = !wr || both;
        waits = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                rd = avs_readdata;
                break;
            end
            waits++;
        end
        tick();
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic jtag_a(input logic [7:0] a, input bit rd);
        jdo = '0; jdo[9:2] = a; jdo[35] = rd; ta_a = 1'b1;
        tick();
        ta_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0; jdo[34:3] = d; ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (monitor_ready) break;
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", 32'(monitor_ready), 0);
        check("rst_error", 32'(monitor_error), 0);
        check("rst_mondreg", MonDReg, 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_busy", 32'(jtag_busy), 0);
        check("rst_waitreq", 32'(avs_waitrequest), 1);
        tick();
        reset = 1'b0;
        ref_jaddr = '0;
        tick();
    endtask

    // Reference: memory contents and JTAG address pointer from the command semantics.
    task automatic model(input vec_t v, output logic [31:0] exp, output int lat);
        exp = '0; lat = 0;
        case (v.kind)
            0: begin
                if (v.da) begin ref_mem[v.addr] = v.data; ref_valid[v.addr] = 1'b1; end
                lat = 1;
            end
            1: begin exp = ref_mem[v.addr]; lat = 2; end
            2: begin
                ref_mem[v.addr] = v.data; ref_valid[v.addr] = 1'b1;
                ref_jaddr = v.addr + 8'd1; lat = 3;
            end
            3: begin
                ref_mem[ref_jaddr] = v.data; ref_valid[ref_jaddr] = 1'b1;
                ref_jaddr = ref_jaddr + 8'd1; lat = 3;
            end
            default: begin exp = ref_mem[v.addr]; ref_jaddr = v.addr + 8'd1; lat = 4; end
        endcase
    endtask

    task automatic run_op(input vec_t v, output logic [31:0] got, output int lat);
        got = '0;
        case (v.kind)
            0: cpu_op(1'b1, 1'b0, v.addr, v.data, v.da, got, lat);
            1: cpu_op(1'b0, 1'b0, v.addr, 32'h0, 1'b1, got, lat);
            2: begin jtag_a(v.addr, 1'b0); jtag_b(v.data); wait_ready(lat); end
            3: begin jtag_b(v.data); wait_ready(lat); end
            default: begin jtag_a(v.addr, 1'b1); wait_ready(lat); got = MonDReg; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[13];
        vec_t        v;
        logic [31:0] got, mexp, rd;
        int          lat, mlat, waits;

        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end
        tbl = '{
            '{2, 8'h10, 32'hDEADBEEF, 1'b1, 32'h0,        3},
            '{4, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF, 4},
            '{3, 8'h00, 32'h11111111, 1'b1, 32'h0,        3},
            '{1, 8'h11, 32'h0,        1'b1, 32'h11111111, 2},
            '{0, 8'h20, 32'h12345678, 1'b1, 32'h0,        1},
            '{1, 8'h20, 32'h0,        1'b1, 32'h12345678, 2},
            '{0, 8'h20, 32'hAAAA5555, 1'b0, 32'h0,        1},
            '{1, 8'h20, 32'h0,        1'b1, 32'h12345678, 2},
            '{2, 8'hFF, 32'h0BADF00D, 1'b1, 32'h0,        3},
            '{3, 8'h00, 32'hCAFEF00D, 1'b1, 32'h0,        3},
            '{1, 8'h00, 32'h0,        1'b1, 32'hCAFEF00D, 2},
            '{4, 8'hFF, 32'h0,        1'b1, 32'h0BADF00D, 4},
            '{1, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF, 2}
        };

        no_we_window = 1'b1;
        do_reset();
        no_we_window = 1'b0;
        check("rst_no_we", 32'(we_viol), 0);

        for (int i = 0; i < 13; i++) begin
            model(tbl[i], mexp, mlat);
            run_op(tbl[i], got, lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].kind == 1 || tbl[i].kind == 4)
                check($sformatf("tbl%0d_data", i), got, tbl[i].exp);
        end
        check("tbl_error_clear", 32'(monitor_error), 0);

        for (int i = 0; i < 150; i++) begin
            v.kind = int'($urandom_range(0, 4));
            v.addr = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            v.data = $urandom;
            v.da   = ($urandom_range(0, 3) != 0);
            v.exp  = '0; v.lat = 0;
            if ((v.kind == 1 || v.kind == 4) && !ref_valid[v.addr]) begin
                v.kind = 0; v.da = 1'b1;
            end
            model(v, mexp, mlat);
            run_op(v, got, lat);
            check($sformatf("rnd%0d_k%0d_lat", i, v.kind), 32'(lat), 32'(mlat));
            if (v.kind == 1 || v.kind == 4)
                check($sformatf("rnd%0d_k%0d_data", i, v.kind), got, mexp);
        end

        // Tie right after reset: JTAG wins, CPU write waits out the whole JTAG read.
        do_reset();
        jtag_a(8'h20, 1'b1);
        cpu_op(1'b1, 1'b0, 8'h30, 32'h30303030, 1'b1, rd, waits);
        check("tie1_cpu_waits", 32'(waits), 4);
        check("tie1_jtag_ready", 32'(monitor_ready), 1);
        check("tie1_jtag_data", MonDReg, 32'h12345678);
        jtag_a(8'h40, 1'b0);
        jtag_b(32'h40404040);
        wait_ready(lat);
        check("lone_jtag_lat", 32'(lat), 3);
        // Last grant was JTAG, so this tie goes to the CPU.
        jtag_b(32'h41414141);
        cpu_op(1'b1, 1'b0, 8'h31, 32'h31313131, 1'b1, rd, waits);
        check("tie2_cpu_waits", 32'(waits), 1);
        check("tie2_jtag_not_ready", 32'(monitor_ready), 0);
        wait_ready(lat);
        check("tie2_jtag_lat", 32'(lat), 3);
        cpu_op(1'b0, 1'b0, 8'h30, 32'h0, 1'b1, rd, waits);
        check("tie1_cpu_wr_data", rd, 32'h30303030);
        cpu_op(1'b0, 1'b0, 8'h41, 32'h0, 1'b1, rd, waits);
        check("tie2_jtag_wr_data", rd, 32'h41414141);
        cpu_op(1'b0, 1'b0, 8'h31, 32'h0, 1'b1, rd, waits);
        check("tie2_cpu_wr_data", rd, 32'h31313131);

        // Read and write asserted together behave as a write.
        cpu_op(1'b1, 1'b1, 8'h22, 32'h0C0FFEE0, 1'b1, rd, waits);
        check("both_waits", 32'(waits), 1);
        cpu_op(1'b0, 1'b0, 8'h22, 32'h0, 1'b1, rd, waits);
        check("both_data", rd, 32'h0C0FFEE0);

        // Strobe while a JTAG read is pending is dropped and flagged.
        jtag_a(8'h20, 1'b1);
        jtag_b(32'hBAD0BAD0);
        check("drop_error", 32'(monitor_error), 1);
        wait_ready(lat);
        check("drop_read_data", MonDReg, 32'h12345678);
        check("drop_error_sticky", 32'(monitor_error), 1);
        cpu_op(1'b0, 1'b0, 8'h21, 32'h0, 1'b1, rd, waits);
        check("drop_no_write", rd, 32'h0 | mem[8'h21]);

        // Simultaneous a+b: a takes effect, b is dropped.
        jdo = '0; jdo[9:2] = 8'h60; ta_a = 1'b1; ta_b = 1'b1;
        tick();
        ta_a = 1'b0; ta_b = 1'b0;
        check("ab_error", 32'(monitor_error), 1);
        check("ab_not_busy", 32'(jtag_busy), 0);
        jtag_b(32'h60606060);
        wait_ready(lat);
        check("ab_b_lat", 32'(lat), 3);
        cpu_op(1'b0, 1'b0, 8'h60, 32'h0, 1'b1, rd, waits);
        check("ab_addr_taken", rd, 32'h60606060);
        jtag_a(8'h50, 1'b0);
        check("a_clears_error", 32'(monitor_error), 0);
        check("a_clears_ready", 32'(monitor_ready), 0);

        // Strobe in the completion (WR) cycle is accepted.
        jtag_a(8'h70, 1'b0);
        jtag_b(32'h70707070);
        tick();
        jtag_a(8'h20, 1'b1);
        check("cpl_no_error", 32'(monitor_error), 0);
        wait_ready(lat);
        check("cpl_rd_lat", 32'(lat), 4);
        check("cpl_rd_data", MonDReg, 32'h12345678);
        cpu_op(1'b0, 1'b0, 8'h70, 32'h0, 1'b1, rd, waits);
        check("cpl_wr_data", rd, 32'h70707070);

        // Reset during RD_ADDR of a JTAG read aborts it silently.
        jtag_a(8'h20, 1'b1);
        tick();
        reset = 1'b1; no_we_window = 1'b1;
        @(negedge clk);
        check("rst_mid_waitreq", 32'(avs_waitrequest), 1);
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 32'(jtag_busy), 0);
        repeat (3) tick();
        check("rst_mid_ready", 32'(monitor_ready), 0);
        no_we_window = 1'b0;
        check("rst_mid_no_we", 32'(we_viol), 0);
        cpu_op(1'b1, 1'b0, 8'h23, 32'h23232323, 1'b1, rd, waits);
        check("rst_mid_idle_waits", 32'(waits), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
